// File: rtl/bcd_seq_pkg.sv
// Shared encodings for the BCD count sequencer: command opcodes, FSM states
// and the largest legal BCD digit value.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_count_sequencer_if.sv
// Command handshake and counter status bundle between a host (master) and
// the BCD count sequencer (slave).
interface bcd_count_sequencer_if #(
  parameter int NDIG   = 2,
  parameter int STEP_W = 8
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [4*NDIG-1:0]   cmd_load_val;
  logic [STEP_W-1:0]   cmd_steps;
  logic                pause;
  logic [4*NDIG-1:0]   q;
  logic                busy;
  logic                done;
  logic                wrap;
  logic                err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_load_val, cmd_steps, pause,
    output cmd_ready, q, busy, done, wrap, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_load_val, cmd_steps, pause,
    input  cmd_ready, q, busy, done, wrap, err
  );

endinterface

// File: rtl/bcd_count_sequencer_bcd_digit.sv
// One BCD up/down digit with parallel load; term flags the carry/borrow
// terminal value for the current direction.
module bcd_digit
  import bcd_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       term
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      if (up) q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      else    q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 4'd0;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign term = up ? (q_q == BCD_MAX) : (q_q == 4'd0);

endmodule

// File: rtl/bcd_count_sequencer.sv
// Command-driven sequencer for a chain of cascaded BCD digits: CLEAR, LOAD,
// UP-by-N and DOWN-by-N, one count step per unpaused clock.
//   state | meaning
//   IDLE  | ready for a command; accept edge performs CLEAR/LOAD or step 1
//   RUN   | stepping once per unpaused edge until the remaining count expires
module bcd_count_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int NDIG   = 2,
  parameter int STEP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_count_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                up_q, up_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                wrap_q, wrap_d;

  op_e                 op;
  logic                accept, load_ok, step_en, step_up, dig_ld, wrap_now;
  logic [NDIG-1:0]     dig_en, dig_term;
  logic [4*NDIG-1:0]   dig_d, q_vec;

  assign op     = op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && (state_q == IDLE);

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (bus.cmd_load_val[4*i +: 4] > BCD_MAX) load_ok = 1'b0;
    end
  end

  // The accept edge already performs step 1, so direction comes from the
  // command itself there and from the latched copy afterwards.
  assign step_en = (accept && bus.cmd_op[1] && (bus.cmd_steps != '0))
                || ((state_q == RUN) && !bus.pause);
  assign step_up = accept ? (op == OP_UP) : up_q;
  assign dig_ld  = accept && ((op == OP_CLEAR) || ((op == OP_LOAD) && load_ok));
  assign dig_d   = (op == OP_LOAD) ? bus.cmd_load_val : '0;

  always_comb begin
    dig_en    = '0;
    dig_en[0] = step_en;
    for (int i = 1; i < NDIG; i++) begin
      dig_en[i] = dig_en[i-1] && dig_term[i-1];
    end
  end

  assign wrap_now = step_en && (&dig_term);

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit u_dig (
      .clk  (clk),
      .rst  (rst),
      .en   (dig_en[g]),
      .up   (step_up),
      .ld   (dig_ld),
      .d    (dig_d[4*g +: 4]),
      .q    (q_vec[4*g +: 4]),
      .term (dig_term[g])
    );
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    up_d    = up_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wrap_d  = wrap_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wrap_d = wrap_now;
          up_d   = (op == OP_UP);
          unique case (op)
            OP_CLEAR: done_d = 1'b1;
            OP_LOAD: begin
              done_d = 1'b1;
              err_d  = !load_ok;
            end
            OP_UP, OP_DOWN: begin
              if (bus.cmd_steps == '0) begin
                done_d = 1'b1;
              end else begin
                rem_d = bus.cmd_steps - STEP_W'(1);
                if (bus.cmd_steps == STEP_W'(1)) done_d  = 1'b1;
                else                             state_d = RUN;
              end
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (!bus.pause) begin
          rem_d = rem_q - STEP_W'(1);
          if (wrap_now) wrap_d = 1'b1;
          if (rem_q == STEP_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      up_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      up_q    <= up_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.q         = q_vec;
  assign bus.busy      = (state_q == RUN);
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Bench for bcd_count_sequencer: command table, hand-written pause/reset
// sequences and random commands against an integer-valued reference model.
module tb_bcd_count_sequencer;

  localparam int NDIG   = 2;
  localparam int STEP_W = 8;
  localparam int M      = 10 ** NDIG;
  localparam int W      = 4 * NDIG;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_count_sequencer_if #(.NDIG(NDIG), .STEP_W(STEP_W)) bus ();

  bcd_count_sequencer #(.NDIG(NDIG), .STEP_W(STEP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: counter held as a plain integer 0..M-1
  int m_val  = 0;
  int m_rem  = 0;
  bit m_run  = 0;
  bit m_up   = 0;
  bit m_wrap = 0;
  bit m_done = 0;
  bit m_err  = 0;

  typedef struct {
    logic [1:0]        op;
    logic [W-1:0]      load;
    logic [STEP_W-1:0] steps;
    logic [W-1:0]      exp_q;
    bit                exp_wrap;
    bit                exp_err;
  } vec_t;

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(logic [W-1:0] b);
    for (int i = 0; i < NDIG; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(logic [W-1:0] b);
    int v, scale;
    v = 0;
    scale = 1;
    for (int i = 0; i < NDIG; i++) begin
      v = v + int'(b[4*i +: 4]) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  task automatic model_count();
    if (m_up) begin
      if (m_val == M - 1) begin m_val = 0; m_wrap = 1; end
      else m_val = m_val + 1;
    end else begin
      if (m_val == 0) begin m_val = M - 1; m_wrap = 1; end
      else m_val = m_val - 1;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_val = 0; m_rem = 0; m_run = 0; m_wrap = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (!m_run && bus.cmd_valid) begin
        m_wrap = 0;
        case (bus.cmd_op)
          2'b00: begin m_val = 0; m_done = 1; end
          2'b01: begin
            if (bcd_ok(bus.cmd_load_val)) m_val = from_bcd(bus.cmd_load_val);
            else m_err = 1;
            m_done = 1;
          end
          default: begin
            if (bus.cmd_steps == 0) begin
              m_done = 1;
            end else begin
              m_up = (bus.cmd_op == 2'b10);
              model_count();
              m_rem = int'(bus.cmd_steps) - 1;
              if (m_rem == 0) m_done = 1;
              else m_run = 1;
            end
          end
        endcase
      end else if (m_run && !bus.pause) begin
        model_count();
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_run = 0; m_done = 1; end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: advance the model on the inputs now applied, then compare
  task automatic tick();
    logic [W+4:0] act, exp;
    model_step();
    @(posedge clk);
    #1;
    act = {bus.q, bus.busy, bus.done, bus.wrap, bus.err, bus.cmd_ready};
    exp = {to_bcd(m_val), m_run, m_done, m_wrap, m_err, !m_run};
    check("cycle {q,busy,done,wrap,err,ready}", 32'(act), 32'(exp));
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] load,
                         input logic [STEP_W-1:0] steps, input bit rand_pause,
                         output bit err_seen);
    bit got;
    got = 0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = op;
    bus.cmd_load_val = load;
    bus.cmd_steps    = steps;
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (bus.done) begin got = 1; break; end
      bus.pause = rand_pause && ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.pause = 1'b0;
    err_seen  = bus.err;
    if (!got) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  vec_t tbl[15];

  initial begin
    bit e;
    logic [1:0]   rop;
    logic [W-1:0] rld;
    logic [STEP_W-1:0] rst_steps;

    tbl[0]  = '{2'b01, 8'h47, 8'd0,   8'h47, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 8'h97, 8'd0,   8'h97, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 8'h00, 8'd5,   8'h02, 1'b1, 1'b0};
    tbl[3]  = '{2'b01, 8'h01, 8'd0,   8'h01, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 8'h00, 8'd3,   8'h98, 1'b1, 1'b0};
    tbl[5]  = '{2'b00, 8'h00, 8'd0,   8'h00, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 8'h98, 8'd0,   8'h98, 1'b0, 1'b0};
    tbl[7]  = '{2'b01, 8'h3A, 8'd0,   8'h98, 1'b0, 1'b1};
    tbl[8]  = '{2'b01, 8'h10, 8'd0,   8'h10, 1'b0, 1'b0};
    tbl[9]  = '{2'b10, 8'h00, 8'd0,   8'h10, 1'b0, 1'b0};
    tbl[10] = '{2'b11, 8'h00, 8'd11,  8'h99, 1'b1, 1'b0};
    tbl[11] = '{2'b10, 8'h00, 8'd1,   8'h00, 1'b1, 1'b0};
    tbl[12] = '{2'b01, 8'h9F, 8'd0,   8'h00, 1'b0, 1'b1};
    tbl[13] = '{2'b10, 8'h00, 8'd255, 8'h55, 1'b1, 1'b0};
    tbl[14] = '{2'b11, 8'h00, 8'd200, 8'h55, 1'b1, 1'b0};

    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = 2'b00;
    bus.cmd_load_val = '0;
    bus.cmd_steps    = '0;
    bus.pause        = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      run_cmd(tbl[i].op, tbl[i].load, tbl[i].steps, 1'b0, e);
      check($sformatf("tbl%0d_q", i), 32'(bus.q), 32'(tbl[i].exp_q));
      check($sformatf("tbl%0d_wrap", i), 32'(bus.wrap), 32'(tbl[i].exp_wrap));
      check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
    end
    tick();
    check("err_one_cycle", 32'(bus.err), 32'd0);

    // pause in RUN with a LOAD held on the bus until IDLE returns
    run_cmd(2'b01, 8'h10, 8'd0, 1'b0, e);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_steps = 8'd4;
    tick();
    check("p_step1", 32'(bus.q), 32'h11);
    bus.cmd_op = 2'b01; bus.cmd_load_val = 8'h33;
    tick();
    check("p_step2", 32'(bus.q), 32'h12);
    bus.pause = 1'b1;
    tick();
    check("p_hold1", 32'(bus.q), 32'h12);
    tick();
    check("p_hold2", 32'(bus.q), 32'h12);
    check("p_busy", 32'(bus.busy), 32'd1);
    bus.pause = 1'b0;
    tick();
    check("p_step3", 32'(bus.q), 32'h13);
    tick();
    check("p_step4", 32'(bus.q), 32'h14);
    check("p_done", 32'(bus.done), 32'd1);
    tick();
    check("p_load_after", 32'(bus.q), 32'h33);
    bus.cmd_valid = 1'b0;
    tick();

    // synchronous reset in the middle of a long count
    run_cmd(2'b01, 8'h50, 8'd0, 1'b0, e);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_steps = 8'd20;
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("r_q", 32'(bus.q), 32'h00);
    check("r_busy", 32'(bus.busy), 32'd0);
    check("r_ready", 32'(bus.cmd_ready), 32'd1);
    check("r_wrap", 32'(bus.wrap), 32'd0);
    rst = 1'b0;
    run_cmd(2'b10, 8'h00, 8'd0, 1'b0, e);
    check("r_zero_steps_q", 32'(bus.q), 32'h00);

    for (int n = 0; n < 150; n++) begin
      rop = 2'($urandom_range(0, 3));
      rld = W'($urandom);
      if ($urandom_range(0, 1) == 0) rld = to_bcd($urandom_range(0, M - 1));
      rst_steps = ($urandom_range(0, 9) == 0) ? STEP_W'($urandom) : STEP_W'($urandom_range(0, 40));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      run_cmd(rop, rld, rst_steps, 1'b1, e);
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
